instr_fetch_unit: RTL and testbench

Multicycle instruction fetch stage that sits directly upstream of the control unit. It owns the PC register and issues reads to the 32-bit instruction memory, which has a fixed latency. It latches the returned word into the instruction register and presents the full instruction and its 7-bit opcode to the control unit. It also accepts branch-target PC loads produced during beq/bne resolution.

---
 rtl/instr_fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multicycle instruction fetch stage with PC, IR and branch-target loads
//
// Purpose:
//   Owns the PC, issues one read per fetch to a fixed-latency 32-bit
//   instruction memory, latches the returned word into the instruction
//   register and hands instruction and opcode to the control unit.
//   Branch targets may be loaded while idle or deferred while a fetch is busy.
//
// Parameters:
//   RESET_PC     PC value after reset
//   MEM_LATENCY  cycles from mem_rd_en to valid mem_rdata (1..15)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous reset, active HIGH despite the name
//   fetch_req     one-cycle request for the next instruction
//   pc_load       load pc_target into PC (branch taken)
//   pc_target     branch target address
//   mem_rdata     instruction memory read data
//   fetch_ready   idle and able to accept fetch_req
//   instr_valid   one-cycle pulse with a freshly fetched instruction
//   instrucao     instruction register
//   opcode        instrucao[6:0]
//   pc_out        current PC
//   mem_addr      instruction memory address (holds outside ISSUE)
//   mem_rd_en     one-cycle read strobe
//   misalign_err  sticky: a load with pc_target[1:0] != 0 was seen
//   fetch_count   (FETCH_PERF_CNT_EN) completed fetches
//   stall_count   (FETCH_PERF_CNT_EN) cycles spent waiting on memory
//
// Optional feature macro: FETCH_PERF_CNT_EN

module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [63:0] pc_target,
  input  logic [31:0] mem_rdata,
  output logic        fetch_ready,
  output logic        instr_valid,
  output logic [31:0] instrucao,
  output logic [6:0]  opcode,
  output logic [63:0] pc_out,
  output logic [63:0] mem_addr,
  output logic        mem_rd_en,
  output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  lat_cnt;
  logic        pend_v;
  logic [63:0] pend_pc;
  logic        load_ok;
  logic        load_bad;

  // Misaligned targets are dropped entirely; only the sticky flag records them.
  assign load_ok  = pc_load && (pc_target[1:0] == 2'b00);
  assign load_bad = pc_load && (pc_target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fetch_ready = 1'b0;
    instr_valid = 1'b0;
    mem_rd_en   = 1'b0;
    case (state)
      IDLE: begin
        fetch_ready = 1'b1;
        if (fetch_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_rd_en = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        instr_valid = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_addr doubles as the fetch address register: it is written only when
  // a fetch is accepted and holds until the next one, so DONE can use it.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mem_addr <= RESET_PC;
    end else if (state == IDLE && fetch_req) begin
      mem_addr <= load_ok ? pc_target : pc_out;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      lat_cnt   <= 4'd0;
      instrucao <= 32'h0;
    end else begin
      case (state)
        ISSUE: lat_cnt <= LAT_INIT;
        WAIT: begin
          if (lat_cnt == 4'd0) instrucao <= mem_rdata;
          else                 lat_cnt   <= lat_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign opcode = instrucao[6:0];

  // PC and deferred branch target. A load arriving in DONE itself is the
  // newest one, so it wins over any pending target and over PC + 4.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_out  <= RESET_PC;
      pend_v  <= 1'b0;
      pend_pc <= 64'h0;
    end else begin
      case (state)
        IDLE: begin
          if (load_ok) pc_out <= pc_target;
        end
        ISSUE, WAIT: begin
          if (load_ok) begin
            pend_v  <= 1'b1;
            pend_pc <= pc_target;
          end
        end
        DONE: begin
          pend_v <= 1'b0;
          if (load_ok)     pc_out <= pc_target;
          else if (pend_v) pc_out <= pend_pc;
          else             pc_out <= mem_addr + 64'd4;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)         misalign_err <= 1'b0;
    else if (load_bad) misalign_err <= 1'b1;
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (state == DONE) fetch_count <= fetch_count + 32'd1;
      if (state == WAIT) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - table-driven self-checking bench for instr_fetch_unit

module tb_instr_fetch_unit;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [63:0] pc_target = 64'h0;
  logic [31:0] mem_rdata;
  logic        fetch_ready, instr_valid, mem_rd_en, misalign_err;
  logic [31:0] instrucao;
  logic [6:0]  opcode;
  logic [63:0] pc_out, mem_addr;

  logic        fetch_req1 = 1'b0;
  logic [31:0] mem_rdata1;
  logic        fetch_ready1, instr_valid1, mem_rd_en1, misalign_err1;
  logic [31:0] instrucao1;
  logic [6:0]  opcode1;
  logic [63:0] pc_out1, mem_addr1;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count, fetch_count1, stall_count1;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(64'h0), .MEM_LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_target(pc_target), .mem_rdata(mem_rdata), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instrucao(instrucao), .opcode(opcode),
    .pc_out(pc_out), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .misalign_err(misalign_err)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  instr_fetch_unit #(.RESET_PC(64'h0), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst), .fetch_req(fetch_req1), .pc_load(1'b0),
    .pc_target(64'h0), .mem_rdata(mem_rdata1), .fetch_ready(fetch_ready1),
    .instr_valid(instr_valid1), .instrucao(instrucao1), .opcode(opcode1),
    .pc_out(pc_out1), .mem_addr(mem_addr1), .mem_rd_en(mem_rd_en1),
    .misalign_err(misalign_err1)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count1), .stall_count(stall_count1)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a == 64'h0) ? 32'h00500093 : {a[23:0], 8'h6F};
  endfunction

  // Memory models: data is valid only in the exact cycle the latency allows.
  logic [1:0]  pv = 2'b00;
  logic [63:0] pa0 = 64'h0, pa1 = 64'h0;
  logic        pv1 = 1'b0;
  logic [63:0] pb0 = 64'h0;
  always @(posedge clk) begin
    pv  <= {pv[0], mem_rd_en};
    pa0 <= mem_addr;
    pa1 <= pa0;
    pv1 <= mem_rd_en1;
    pb0 <= mem_addr1;
  end
  assign mem_rdata  = pv[1] ? mem_word(pa1) : 32'hDEADBEEF;
  assign mem_rdata1 = pv1   ? mem_word(pb0) : 32'hDEADBEEF;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        freq;
    logic        load;
    logic [63:0] target;
    logic        ready;
    logic        valid;
    logic        rden;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] addr;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic f, input logic l, input logic [63:0] t,
                     input logic rdy, input logic v, input logic rd,
                     input logic [31:0] ins, input logic [63:0] pc,
                     input logic [63:0] ad, input logic e);
    vec_t r;
    r.freq = f; r.load = l; r.target = t; r.ready = rdy; r.valid = v;
    r.rden = rd; r.instr = ins; r.pc = pc; r.addr = ad; r.err = e;
    tbl.push_back(r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one fetch; checks request-to-valid latency and returns the word.
  task automatic do_fetch(input string name, output logic [31:0] ins);
    int n;
    fetch_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      fetch_req = 1'b0;
      n++;
    end while (!instr_valid && n < 20);
    chk({name, "_latency"}, 64'(n), 64'(LAT + 2));
    ins = instrucao;
    @(negedge clk);
  endtask

  logic [31:0] w;
  int vcount;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    //   freq load target      rdy v rd instr          pc      addr   err
    row(1, 0, 64'h0,  1, 0, 0, 32'h0,        64'h0,  64'h0,  0); // r0
    row(0, 0, 64'h0,  0, 0, 1, 32'h0,        64'h0,  64'h0,  0);
    row(0, 0, 64'h0,  0, 0, 0, 32'h0,        64'h0,  64'h0,  0);
    row(1, 0, 64'h0,  0, 0, 0, 32'h0,        64'h0,  64'h0,  0); // req ignored
    row(0, 0, 64'h0,  0, 1, 0, 32'h00500093, 64'h0,  64'h0,  0);
    row(1, 0, 64'h0,  1, 0, 0, 32'h00500093, 64'h4,  64'h0,  0); // r5
    row(0, 0, 64'h0,  0, 0, 1, 32'h00500093, 64'h4,  64'h4,  0);
    row(0, 0, 64'h0,  0, 0, 0, 32'h00500093, 64'h4,  64'h4,  0);
    row(0, 0, 64'h0,  0, 0, 0, 32'h00500093, 64'h4,  64'h4,  0);
    row(0, 0, 64'h0,  0, 1, 0, 32'h0000046F, 64'h4,  64'h4,  0);
    row(1, 0, 64'h0,  1, 0, 0, 32'h0000046F, 64'h8,  64'h4,  0); // r10
    row(0, 0, 64'h0,  0, 0, 1, 32'h0000046F, 64'h8,  64'h8,  0);
    row(0, 1, 64'h40, 0, 0, 0, 32'h0000046F, 64'h8,  64'h8,  0); // load in WAIT
    row(0, 0, 64'h0,  0, 0, 0, 32'h0000046F, 64'h8,  64'h8,  0);
    row(0, 0, 64'h0,  0, 1, 0, 32'h0000086F, 64'h8,  64'h8,  0);
    row(1, 0, 64'h0,  1, 0, 0, 32'h0000086F, 64'h40, 64'h8,  0); // r15
    row(0, 0, 64'h0,  0, 0, 1, 32'h0000086F, 64'h40, 64'h40, 0);
    row(0, 0, 64'h0,  0, 0, 0, 32'h0000086F, 64'h40, 64'h40, 0);
    row(0, 0, 64'h0,  0, 0, 0, 32'h0000086F, 64'h40, 64'h40, 0);
    row(0, 0, 64'h0,  0, 1, 0, 32'h0000406F, 64'h40, 64'h40, 0);
    row(0, 1, 64'h10, 1, 0, 0, 32'h0000406F, 64'h44, 64'h40, 0); // r20
    row(0, 1, 64'h42, 1, 0, 0, 32'h0000406F, 64'h10, 64'h40, 0); // misaligned
    row(1, 1, 64'h20, 1, 0, 0, 32'h0000406F, 64'h10, 64'h40, 1); // load+fetch
    row(0, 0, 64'h0,  0, 0, 1, 32'h0000406F, 64'h20, 64'h20, 1);
    row(0, 0, 64'h0,  0, 0, 0, 32'h0000406F, 64'h20, 64'h20, 1); // r24 WAIT

    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("r%0d_ready", i), 64'(fetch_ready),  64'(tbl[i].ready));
      chk($sformatf("r%0d_valid", i), 64'(instr_valid),  64'(tbl[i].valid));
      chk($sformatf("r%0d_rden", i),  64'(mem_rd_en),    64'(tbl[i].rden));
      chk($sformatf("r%0d_instr", i), 64'(instrucao),    64'(tbl[i].instr));
      chk($sformatf("r%0d_opcode", i), 64'(opcode),      64'(tbl[i].instr[6:0]));
      chk($sformatf("r%0d_pc", i),    pc_out,            tbl[i].pc);
      chk($sformatf("r%0d_addr", i),  mem_addr,          tbl[i].addr);
      chk($sformatf("r%0d_err", i),   64'(misalign_err), 64'(tbl[i].err));
      fetch_req = tbl[i].freq;
      pc_load   = tbl[i].load;
      pc_target = tbl[i].target;
    end
    fetch_req = 1'b0;
    pc_load   = 1'b0;

    // Asynchronous reset in the middle of WAIT: takes effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 64'(fetch_ready), 64'd1);
    chk("arst_pc",    pc_out,           64'h0);
    chk("arst_addr",  mem_addr,         64'h0);
    chk("arst_instr", 64'(instrucao),   64'h0);
    chk("arst_err",   64'(misalign_err), 64'd0);
    chk("arst_rden",  64'(mem_rd_en),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (instr_valid) vcount++;
    end
    chk("arst_no_valid", 64'(vcount), 64'd0);
    chk("arst_instr_after", 64'(instrucao), 64'h0);
    chk("arst_pc_after", pc_out, 64'h0);

    // Misaligned load with a simultaneous fetch: fetch uses the current PC.
    pc_load = 1'b1; pc_target = 64'h43; fetch_req = 1'b1;
    @(negedge clk);
    pc_load = 1'b0; fetch_req = 1'b0;
    chk("mis_fetch_rden", 64'(mem_rd_en), 64'd1);
    chk("mis_fetch_addr", mem_addr, 64'h0);
    chk("mis_fetch_err",  64'(misalign_err), 64'd1);
    chk("mis_fetch_pc",   pc_out, 64'h0);
    vcount = 0;
    while (!instr_valid && vcount < 20) begin
      @(negedge clk);
      vcount++;
    end
    chk("mis_fetch_instr", 64'(instrucao), 64'h00500093);
    @(negedge clk);
    chk("mis_fetch_pc_end", pc_out, 64'h4);

    // Pending loads while busy: newest aligned target wins, misaligned dropped.
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    chk("pend_issue_addr", mem_addr, 64'h4);
    pc_load = 1'b1; pc_target = 64'h100;
    @(negedge clk);
    pc_target = 64'h200;
    @(negedge clk);
    pc_target = 64'h301;
    @(negedge clk);
    pc_load = 1'b0;
    chk("pend_done_valid", 64'(instr_valid), 64'd1);
    chk("pend_done_instr", 64'(instrucao), 64'h0000046F);
    @(negedge clk);
    chk("pend_pc", pc_out, 64'h200);
    do_fetch("pend_next", w);
    chk("pend_next_instr", 64'(w), 64'h0002006F);
    chk("pend_next_pc", pc_out, 64'h204);

    // PC + 4 wraps at the top of the address space.
    pc_load = 1'b1; pc_target = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    pc_load = 1'b0;
    chk("wrap_pc_load", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch("wrap", w);
    chk("wrap_instr", 64'(w), 64'hFFFFFC6F);
    chk("wrap_pc", pc_out, 64'h0);
    chk("err_sticky", 64'(misalign_err), 64'd1);

    // Single-cycle latency instance: WAIT lasts exactly one cycle.
    fetch_req1 = 1'b1;
    @(negedge clk);
    fetch_req1 = 1'b0;
    chk("l1_c1_rden", 64'(mem_rd_en1), 64'd1);
    @(negedge clk);
    chk("l1_c2_valid", 64'(instr_valid1), 64'd0);
    chk("l1_c2_ready", 64'(fetch_ready1), 64'd0);
    @(negedge clk);
    chk("l1_c3_valid", 64'(instr_valid1), 64'd1);
    chk("l1_c3_instr", 64'(instrucao1), 64'h00500093);
    @(negedge clk);
    chk("l1_c4_ready", 64'(fetch_ready1), 64'd1);
    chk("l1_c4_pc", pc_out1, 64'h4);

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    chk("perf_reset_fetch", 64'(fetch_count), 64'd0);
    chk("perf_reset_stall", 64'(stall_count), 64'd0);
    do_fetch("perf_f1", w);
    do_fetch("perf_f2", w);
    chk("perf_fetch_count", 64'(fetch_count), 64'd2);
    chk("perf_stall_count", 64'(stall_count), 64'(2 * LAT));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
